// File: rtl/cpu16_pkg.sv
// Shared cpu16 constants: register-file geometry and write-back queue sizing.
package cpu16_pkg;

  localparam int unsigned CpuDw    = 16;
  localparam int unsigned CpuAw    = 3;
  localparam int unsigned WbqDepth = 4;

  // Register 0 is hard-wired to zero, so writes to it are never queued or bypassed.
  localparam int unsigned RegZero  = 0;

endpackage

// File: rtl/wb_queue_if.sv
// Producer-to-queue write channel: valid/ready handshake carrying address and data.
interface wb_queue_if
  import cpu16_pkg::*;
#(
  parameter int unsigned DW = CpuDw,
  parameter int unsigned AW = CpuAw
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match search over the queue entries for one register-file read port.
module wb_bypass_match
  import cpu16_pkg::*;
#(
  parameter int unsigned DW    = CpuDw,
  parameter int unsigned AW    = CpuAw,
  parameter int unsigned DEPTH = WbqDepth
) (
  input  logic [DEPTH-1:0]         ent_valid,
  input  logic [DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [AW-1:0]            ra,
  output logic                     hit,
  output logic [DW-1:0]            bd
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from the head so the last match found wins.
  always_comb begin
    hit = 1'b0;
    bd  = '0;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ra) && (ra != AW'(RegZero))) begin
        hit = 1'b1;
        bd  = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue between result producers and the register file, with
// youngest-match read bypass on two operand ports.
module wb_queue
  import cpu16_pkg::*;
#(
  parameter int unsigned DW    = CpuDw,
  parameter int unsigned AW    = CpuAw,
  parameter int unsigned DEPTH = WbqDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_queue_if.slave              push,
  input  logic                   hold,
  output logic                   we,
  output logic [AW-1:0]          wa,
  output logic [DW-1:0]          wd,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic                   hit1,
  output logic                   hit2,
  output logic [DW-1:0]          bd1,
  output logic [DW-1:0]          bd2,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0][AW-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [PW-1:0]            head_q, tail_q;
  logic [CW-1:0]            count_q;

  logic             nonempty, do_push, do_pop;
  logic [DEPTH-1:0] valid_vis;

  assign nonempty      = (count_q != '0);
  assign push.in_ready = rst || (count_q != CW'(DEPTH));
  // Register-0 writes complete the handshake but never allocate an entry.
  assign do_push       = push.in_valid && push.in_ready && (push.in_addr != AW'(RegZero));
  assign do_pop        = we;

  // Outputs are forced to their idle values while reset is asserted.
  always_comb begin
    we        = !rst && nonempty && !hold;
    wa        = '0;
    wd        = '0;
    count     = rst ? '0 : count_q;
    valid_vis = rst ? '0 : valid_q;
    if (!rst && nonempty) begin
      wa = addr_q[head_q];
      wd = data_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= push.in_addr;
        data_q[tail_q]  <= push.in_data;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  wb_bypass_match #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_match1 (
    .ent_valid (valid_vis),
    .ent_addr  (addr_q),
    .ent_data  (data_q),
    .head      (head_q),
    .ra        (ra1),
    .hit       (hit1),
    .bd        (bd1)
  );

  wb_bypass_match #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_match2 (
    .ent_valid (valid_vis),
    .ent_addr  (addr_q),
    .ent_data  (data_q),
    .head      (head_q),
    .ra        (ra2),
    .hit       (hit2),
    .bd        (bd2)
  );

endmodule
